dmem_arbiter: RTL and testbench

- Two-master arbiter sharing the single-port data memory between the CPU load/store path (port 0) and a peripheral/DMA engine (port 1).
- Holds a registered ownership state and drives the memory's read/write/address/write-data inputs from the current owner.
- Returns read data, acknowledge and range-error flags per master, plus a stall signal for the CPU.
- Round-robin fairness; optional bus lock with a bounded hold counter.

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arbiter_if.sv | 32 +++
 rtl/dmem_port_mux.sv | 78 +++++++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// default memory size and the address range check also used by the memory.
// No ports; imported by the arbiter top, its port mux and the bus interface users.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  localparam logic [31:0] DMEM_BYTES = 32'h0000_0400;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] limit);
    return addr < limit;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two masters (CPU port 0, DMA port 1), the arbiter
// and the single-port data memory.
// Ports: per-master req/we/addr/wdata (+lock1) in, ack/rdata/err (+stall) out;
// memory mem_read/mem_write/mem_addr/mem_wdata out, mem_rdata in.
interface dmem_arbiter_if;
  logic        req0, we0, ack0, err0, stall;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req1, we1, lock1, ack1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1, lock1,
    input  mem_rdata,
    output ack0, rdata0, err0, stall,
    output ack1, rdata1, err1,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  // Masters plus memory model side.
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1, lock1,
    output mem_rdata,
    input  ack0, rdata0, err0, stall,
    input  ack1, rdata1, err1,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_mux.sv
// Combinational owner select: routes the owning master onto the memory,
// range-checks its address and returns ack/err/rdata to each master.
// Latency: 0 (pure combinational). Backpressure: non-owner simply sees ack=0.
// Ports: own0_i/own1_i from the arbiter FSM, per-master request fields in,
// per-master ack/err/rdata out, memory controls out, mem_rdata_i in.
module dmem_port_mux
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] MEM_BYTES = DMEM_BYTES
) (
  input  logic        own0_i,
  input  logic        own1_i,
  input  logic        req0_i,
  input  logic        we0_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] wdata0_i,
  input  logic        req1_i,
  input  logic        we1_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata1_i,
  input  logic [31:0] mem_rdata_i,
  output logic        ack0_o,
  output logic        err0_o,
  output logic [31:0] rdata0_o,
  output logic        ack1_o,
  output logic        err1_o,
  output logic [31:0] rdata1_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o
);

  logic        ack0, ack1, inr0, inr1;
  logic        sel_vld, sel_we, sel_inr;
  logic [31:0] sel_addr, sel_wdata;

  assign inr0 = addr_in_range(addr0_i, MEM_BYTES);
  assign inr1 = addr_in_range(addr1_i, MEM_BYTES);
  assign ack0 = own0_i & req0_i;
  assign ack1 = own1_i & req1_i;

  // At most one ack is ever high; an owner without a request drives zeros.
  always_comb begin
    sel_vld   = 1'b0;
    sel_we    = 1'b0;
    sel_inr   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (ack0) begin
      sel_vld   = 1'b1;
      sel_we    = we0_i;
      sel_inr   = inr0;
      sel_addr  = addr0_i;
      sel_wdata = wdata0_i;
    end else if (ack1) begin
      sel_vld   = 1'b1;
      sel_we    = we1_i;
      sel_inr   = inr1;
      sel_addr  = addr1_i;
      sel_wdata = wdata1_i;
    end
  end

  // Out-of-range accesses are acked with err but never reach the memory.
  assign mem_read_o  = sel_vld & ~sel_we & sel_inr;
  assign mem_write_o = sel_vld &  sel_we & sel_inr;
  assign mem_addr_o  = sel_addr;
  assign mem_wdata_o = sel_wdata;

  assign ack0_o   = ack0;
  assign err0_o   = ack0 & ~inr0;
  assign rdata0_o = (ack0 & ~we0_i & inr0) ? mem_rdata_i : 32'h0;
  assign ack1_o   = ack1;
  assign err1_o   = ack1 & ~inr1;
  assign rdata1_o = (ack1 & ~we1_i & inr1) ? mem_rdata_i : 32'h0;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// (port 0) and a DMA engine (port 1, optional burst lock bounded by MAX_HOLD).
// Latency: 1 cycle from IDLE to grant; owner is served combinationally each
// cycle. Backpressure: a waiting master sees ack=0 (CPU also gets stall).
// Ports: clk, reset (async, active high), bus (slave view of dmem_arbiter_if).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD  = 8,
  parameter logic [31:0] MEM_BYTES = DMEM_BYTES
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);

  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          own_req, oth_req, own_lock, ack0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;       // port 0 wins the first tie
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Requests seen from the owner's point of view; port 0 never locks.
  assign own_req  = (state_q == ST_OWN1) ? bus.req1 : bus.req0;
  assign oth_req  = (state_q == ST_OWN1) ? bus.req0 : bus.req1;
  assign own_lock = (state_q == ST_OWN1) & bus.lock1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        if (bus.req0 && bus.req1) state_d = last_q ? ST_OWN0 : ST_OWN1;
        else if (bus.req0)        state_d = ST_OWN0;
        else if (bus.req1)        state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (oth_req) begin
          if (own_req && own_lock && hold_q < HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end else begin
            // Direct hand-over, no idle bubble.
            state_d = (state_q == ST_OWN0) ? ST_OWN1 : ST_OWN0;
            last_d  = (state_q == ST_OWN1);
            hold_d  = '0;
          end
        end else if (own_req) begin
          if (hold_q < HOLD_MAX) hold_d = hold_q + 1'b1;
        end else begin
          state_d = ST_IDLE;
          last_d  = (state_q == ST_OWN1);
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  dmem_port_mux #(.MEM_BYTES(MEM_BYTES)) u_mux (
    .own0_i      (state_q == ST_OWN0),
    .own1_i      (state_q == ST_OWN1),
    .req0_i      (bus.req0),
    .we0_i       (bus.we0),
    .addr0_i     (bus.addr0),
    .wdata0_i    (bus.wdata0),
    .req1_i      (bus.req1),
    .we1_i       (bus.we1),
    .addr1_i     (bus.addr1),
    .wdata1_i    (bus.wdata1),
    .mem_rdata_i (bus.mem_rdata),
    .ack0_o      (ack0),
    .err0_o      (bus.err0),
    .rdata0_o    (bus.rdata0),
    .ack1_o      (bus.ack1),
    .err1_o      (bus.err1),
    .rdata1_o    (bus.rdata1),
    .mem_read_o  (bus.mem_read),
    .mem_write_o (bus.mem_write),
    .mem_addr_o  (bus.mem_addr),
    .mem_wdata_o (bus.mem_wdata)
  );

  assign bus.ack0  = ack0;
  assign bus.stall = bus.req0 & ~ack0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus a randomized run, all
// checked against a transaction-level model of ownership and memory contents.
module tb_dmem_arbiter;
  localparam int MAX_HOLD = 8;
  localparam logic [31:0] MEMB = 32'h0000_0400;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if bus();

  dmem_arbiter #(.MAX_HOLD(MAX_HOLD), .MEM_BYTES(MEMB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {16'hA5C3, b, ~b};
  endfunction

  // Memory seen by the DUT: combinational read, write on the clock edge.
  logic [31:0] mem [256];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [256];
  int          m_owner;   // -1 = nobody, 0 or 1
  int          m_last;
  int          m_tenure;  // cycles the owner has already kept the bus, capped
  logic        e_ack0, e_ack1, e_err0, e_err1, e_stall, e_mrd, e_mwr;
  logic [31:0] e_rd0, e_rd1, e_maddr, e_mwd;

  function automatic void model_reset();
    m_owner  = -1;
    m_last   = 1;
    m_tenure = 0;
  endfunction

  function automatic void model_outputs();
    logic in0, in1;
    in0    = bus.addr0 < MEMB;
    in1    = bus.addr1 < MEMB;
    e_ack0 = (m_owner == 0) && bus.req0;
    e_ack1 = (m_owner == 1) && bus.req1;
    e_err0 = e_ack0 && !in0;
    e_err1 = e_ack1 && !in1;
    e_rd0  = (e_ack0 && !bus.we0 && in0) ? ref_mem[bus.addr0[9:2]] : 32'h0;
    e_rd1  = (e_ack1 && !bus.we1 && in1) ? ref_mem[bus.addr1[9:2]] : 32'h0;
    e_stall = bus.req0 && !e_ack0;
    e_mrd = 1'b0; e_mwr = 1'b0; e_maddr = 32'h0; e_mwd = 32'h0;
    if (e_ack0) begin
      e_mrd = !bus.we0 && in0; e_mwr = bus.we0 && in0;
      e_maddr = bus.addr0; e_mwd = bus.wdata0;
    end else if (e_ack1) begin
      e_mrd = !bus.we1 && in1; e_mwr = bus.we1 && in1;
      e_maddr = bus.addr1; e_mwd = bus.wdata1;
    end
  endfunction

  // Advance one clock: commit the write, then apply the grant rules.
  function automatic void model_advance();
    bit mine, other, lk;
    if (e_mwr) ref_mem[e_maddr[9:2]] = e_mwd;
    if (m_owner < 0) begin
      m_tenure = 0;
      if (bus.req0 && bus.req1) m_owner = 1 - m_last;
      else if (bus.req0)        m_owner = 0;
      else if (bus.req1)        m_owner = 1;
    end else begin
      mine  = (m_owner == 0) ? bus.req0 : bus.req1;
      other = (m_owner == 0) ? bus.req1 : bus.req0;
      lk    = (m_owner == 1) && bus.lock1;
      if (other) begin
        if (mine && lk && m_tenure < MAX_HOLD - 1) m_tenure++;
        else begin m_last = m_owner; m_owner = 1 - m_owner; m_tenure = 0; end
      end else if (mine) begin
        if (m_tenure < MAX_HOLD - 1) m_tenure++;
      end else begin
        m_last = m_owner; m_owner = -1; m_tenure = 0;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic r0, input logic w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic r1, input logic w1,
                        input logic [31:0] a1, input logic [31:0] d1,
                        input logic l1);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    bus.lock1 = l1;
  endtask

  task automatic begin_cycle();
    @(negedge clk);
    model_outputs();
  endtask

  task automatic end_cycle();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    set_in(1, 1, 32'h44, 32'h1111_2222, 1, 1, 32'h88, 32'h3333_4444, 1);
    model_reset();
    @(negedge clk);
    checks++;
    if ({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_read, bus.mem_write} !== 6'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b want 000000",
        {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_read, bus.mem_write}); end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1} !== 128'h0)
      begin errors++; $display("FAIL reset_data: addr %h wdata %h rd0 %h rd1 %h want all 0",
        bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1); end
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL reset_stall_hi: got %b want 1", bus.stall); end
    bus.req0 = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall_lo: got %b want 0", bus.stall); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_read();
    set_in(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    begin_cycle();
    checks++;
    if ({bus.stall, bus.ack0} !== 2'b10)
      begin errors++; $display("FAIL first_wait: stall,ack0 got %b want 10", {bus.stall, bus.ack0}); end
    end_cycle();
    begin_cycle();
    checks++;
    if ({bus.ack0, bus.mem_read, bus.stall} !== 3'b110)
      begin errors++; $display("FAIL first_grant: ack0,mem_read,stall got %b want 110",
        {bus.ack0, bus.mem_read, bus.stall}); end
    checks++;
    if (bus.rdata0 !== init_word(4))
      begin errors++; $display("FAIL first_rdata: got %h want %h", bus.rdata0, init_word(4)); end
    end_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    begin_cycle();
    end_cycle();
  endtask

  task automatic test_alternate();
    logic [5:0] want0;
    apply_reset();
    want0 = 6'b101010;  // bit c = ack0 expected in cycle c (cycle 0 is idle)
    set_in(1, 0, 32'h20, 0, 1, 1, 32'h20, 32'hDEAD_BEEF, 0);
    for (int c = 0; c < 6; c++) begin
      begin_cycle();
      checks++;
      if ({bus.ack0, bus.ack1} !== {want0[c], (c != 0) && !want0[c]})
        begin errors++; $display("FAIL alt_ack c%0d: ack0,ack1 got %b%b want %b%b", c,
          bus.ack0, bus.ack1, want0[c], (c != 0) && !want0[c]); end
      if (c == 1) begin
        checks++;
        if (bus.rdata0 !== init_word(8))
          begin errors++; $display("FAIL alt_old: got %h want %h", bus.rdata0, init_word(8)); end
      end
      if (c == 3) begin
        checks++;
        if (bus.rdata0 !== 32'hDEAD_BEEF)
          begin errors++; $display("FAIL alt_readback: got %h want deadbeef", bus.rdata0); end
      end
      end_cycle();
    end
  endtask

  task automatic test_lock();
    logic exp1;
    set_in(1, 0, 32'h28, 0, 1, 0, 32'h24, 0, 1);
    for (int c = 0; c < 18; c++) begin
      exp1 = (c % 9) != 8;
      begin_cycle();
      checks++;
      if ({bus.ack0, bus.ack1} !== {!exp1, exp1})
        begin errors++; $display("FAIL lock_ack c%0d: ack0,ack1 got %b%b want %b%b", c,
          bus.ack0, bus.ack1, !exp1, exp1); end
      end_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    begin_cycle();
    end_cycle();
  endtask

  task automatic test_out_of_range();
    apply_reset();
    set_in(1, 1, 32'h400, 32'h1234, 0, 0, 0, 0, 0);
    begin_cycle(); end_cycle();
    begin_cycle();
    checks++;
    if ({bus.ack0, bus.err0, bus.mem_write, bus.mem_read} !== 4'b1100)
      begin errors++; $display("FAIL oor_write: ack0,err0,mem_write,mem_read got %b want 1100",
        {bus.ack0, bus.err0, bus.mem_write, bus.mem_read}); end
    end_cycle();
    set_in(1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    begin_cycle();
    checks++;
    if ({bus.ack0, bus.err0} !== 2'b10 || bus.rdata0 !== init_word(0))
      begin errors++; $display("FAIL oor_unchanged: ack0,err0 %b%b rdata %h want 10 %h",
        bus.ack0, bus.err0, bus.rdata0, init_word(0)); end
    end_cycle();
    set_in(1, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
    begin_cycle();
    checks++;
    if ({bus.ack0, bus.err0, bus.mem_read} !== 3'b110 || bus.rdata0 !== 32'h0)
      begin errors++; $display("FAIL oor_read: ack0,err0,mem_read %b rdata %h want 110 0",
        {bus.ack0, bus.err0, bus.mem_read}, bus.rdata0); end
    end_cycle();
  endtask

  task automatic test_handover();
    set_in(0, 0, 0, 0, 1, 0, 32'h30, 0, 0);
    begin_cycle();
    checks++;
    if ({bus.ack0, bus.ack1, bus.mem_read} !== 3'b000)
      begin errors++; $display("FAIL ho_release: ack0,ack1,mem_read got %b want 000",
        {bus.ack0, bus.ack1, bus.mem_read}); end
    end_cycle();
    begin_cycle();
    checks++;
    if (bus.ack1 !== 1'b1 || bus.rdata1 !== init_word(12))
      begin errors++; $display("FAIL ho_to1: ack1 %b rdata1 %h want 1 %h", bus.ack1, bus.rdata1, init_word(12)); end
    end_cycle();
    set_in(1, 0, 32'h34, 0, 0, 0, 0, 0, 0);
    begin_cycle();
    checks++;
    if ({bus.ack0, bus.ack1, bus.stall} !== 3'b001)
      begin errors++; $display("FAIL ho_swap: ack0,ack1,stall got %b want 001", {bus.ack0, bus.ack1, bus.stall}); end
    end_cycle();
    begin_cycle();
    checks++;
    if (bus.ack0 !== 1'b1 || bus.rdata0 !== init_word(13))
      begin errors++; $display("FAIL ho_to0: ack0 %b rdata0 %h want 1 %h", bus.ack0, bus.rdata0, init_word(13)); end
    end_cycle();
  endtask

  task automatic test_reset_mid_write();
    set_in(0, 0, 0, 0, 1, 1, 32'h40, 32'h5555_AAAA, 0);
    begin_cycle(); end_cycle();
    begin_cycle();
    checks++;
    if ({bus.ack1, bus.mem_write} !== 2'b11)
      begin errors++; $display("FAIL rst_wr_pre: ack1,mem_write got %b want 11", {bus.ack1, bus.mem_write}); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus.ack1, bus.mem_write} !== 2'b00 || bus.mem_addr !== 32'h0)
      begin errors++; $display("FAIL rst_wr_abort: ack1,mem_write %b addr %h want 00 0",
        {bus.ack1, bus.mem_write}, bus.mem_addr); end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    set_in(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    begin_cycle();
    checks++;
    if (bus.ack0 !== 1'b0) begin errors++; $display("FAIL rst_wr_idle: ack0 got %b want 0", bus.ack0); end
    end_cycle();
    begin_cycle();
    checks++;
    if (bus.rdata0 !== init_word(16))
      begin errors++; $display("FAIL rst_wr_mem: got %h want %h", bus.rdata0, init_word(16)); end
    end_cycle();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0] w;
    w = 8'($urandom_range(255));
    if ($urandom_range(7) == 0) return 32'h400 + {22'd0, w, 2'b00};
    return {22'd0, w, 2'b00};
  endfunction

  task automatic test_random();
    logic l1;
    apply_reset();
    l1 = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(7) == 0) l1 = !l1;
      set_in($urandom_range(7) != 0, 1'($urandom_range(1)), rand_addr(), $urandom(),
             $urandom_range(7) != 0, 1'($urandom_range(1)), rand_addr(), $urandom(), l1);
      begin_cycle();
      checks++;
      if ({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.stall} !== {e_ack0, e_ack1, e_err0, e_err1, e_stall})
        begin errors++; $display("FAIL rnd_ctrl c%0d: ack0,ack1,err0,err1,stall got %b want %b", c,
          {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.stall}, {e_ack0, e_ack1, e_err0, e_err1, e_stall}); end
      checks++;
      if (bus.rdata0 !== e_rd0 || bus.rdata1 !== e_rd1)
        begin errors++; $display("FAIL rnd_rdata c%0d: got %h %h want %h %h", c,
          bus.rdata0, bus.rdata1, e_rd0, e_rd1); end
      checks++;
      if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== {e_mrd, e_mwr, e_maddr, e_mwd})
        begin errors++; $display("FAIL rnd_mem c%0d: rd %b wr %b addr %h wd %h want %b %b %h %h", c,
          bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, e_mrd, e_mwr, e_maddr, e_mwd); end
      end_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_first_read();
    test_alternate();
    test_lock();
    test_out_of_range();
    test_handover();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
